// File: rtl/spi_master_ctrl.sv
// SPI master: one 8-bit full-duplex transfer per start, IDLE->SETUP->SHIFT->HOLD->GAP.
// Define SPI_MSB_FIRST_EN to shift MSB first; LSB first otherwise.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 4,
  parameter int CS_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [7:0]        tx_data,
  output logic [7:0]        rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs,
  output logic              load,
  output logic              check1,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        edge_q;
  logic              cpol_q, cpha_q;
  logic [7:0]        tx_q, rx_sr_q, rx_q;
  logic              sclk_q, busy_q, done_q, load_q, check1_q, mosi_q;
  logic [NUM_CS-1:0] cs_q;

  logic [NUM_CS-1:0] sel_mask;
  logic              div_last;
  logic [2:0]        smp_idx, drv_idx;

  // Maps the k-th transferred bit to its position in the byte.
  function automatic logic [2:0] bit_pos(input logic [2:0] k);
`ifdef SPI_MSB_FIRST_EN
    return 3'd7 - k;
`else
    return k;
`endif
  endfunction

  // Out-of-range cs_sel leaves every chip select high.
  always_comb begin
    sel_mask = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) sel_mask[i] = 1'b0;
  end

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign smp_idx  = edge_q[3:1];
  // cpha=0 drives bit k+1 on trailing edge 2k+1; cpha=1 drives bit k on leading edge 2k.
  assign drv_idx  = edge_q[3:1] + {2'b00, ~cpha_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      edge_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      tx_q     <= '0;
      rx_sr_q  <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      check1_q <= 1'b0;
      mosi_q   <= 1'b0;
      cs_q     <= '1;
    end else begin
      done_q <= 1'b0;
      load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= cpol_q;
          if (start) begin
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            tx_q     <= tx_data;
            cs_q     <= sel_mask;
            check1_q <= 1'b1;
            busy_q   <= 1'b1;
            sclk_q   <= cpol;
            mosi_q   <= cpha ? 1'b0 : tx_data[bit_pos(3'd0)];
            div_q    <= '0;
            edge_q   <= '0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          div_q <= div_last ? '0 : div_q + 1'b1;
          if (div_q == '0) load_q <= 1'b1;
          if (div_last) state_q <= SHIFT;
        end
        SHIFT: begin
          div_q <= div_last ? '0 : div_q + 1'b1;
          if (div_last) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 4'd1;
            if (edge_q[0] == cpha_q)
              rx_sr_q[bit_pos(smp_idx)] <= MISO;
            else if (cpha_q || edge_q != 4'd15)
              mosi_q <= tx_q[bit_pos(drv_idx)];
            if (edge_q == 4'd15) state_q <= HOLD;
          end
        end
        HOLD: begin
          div_q <= div_last ? '0 : div_q + 1'b1;
          if (div_last) begin
            cs_q     <= '1;
            check1_q <= 1'b0;
            state_q  <= GAP;
          end
        end
        GAP: begin
          div_q <= div_last ? '0 : div_q + 1'b1;
          if (div_last) begin
            rx_q    <= rx_sr_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign load    = load_q;
  assign check1  = check1_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: modes, timing, handshake, chip selects, reset abort.
module tb_spi_master_ctrl;

  localparam int NUM_CS = 4;

  logic clk, reset, start, cpol, cpha, MISO;
  logic [1:0] cs_sel;
  logic [7:0] tx_data, rx_data;
  logic busy, done, sclk, load, check1, MOSI;
  logic [NUM_CS-1:0] cs;

  spi_master_ctrl #(.CLK_DIV(4), .NUM_CS(NUM_CS), .CS_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
    .done(done), .sclk(sclk), .cs(cs), .load(load), .check1(check1),
    .MOSI(MOSI), .MISO(MISO)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model: preload on load, shift on sclk falling edge (mode 0)
  logic       loopback;
  logic [7:0] slave_byte, slave_sr;
  logic       sclk_d;
  always @(posedge clk) begin
    sclk_d <= sclk;
    if (load) slave_sr <= slave_byte;
`ifdef SPI_MSB_FIRST_EN
    else if (sclk_d && !sclk && cs != '1) slave_sr <= {slave_sr[6:0], 1'b0};
`else
    else if (sclk_d && !sclk && cs != '1) slave_sr <= {1'b0, slave_sr[7:1]};
`endif
  end
`ifdef SPI_MSB_FIRST_EN
  assign MISO = loopback ? MOSI : slave_sr[7];
`else
  assign MISO = loopback ? MOSI : slave_sr[0];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // transfer observations
  int         lat, cs_low_cnt, load_cnt, load_bad, busy_drop, bad_cs, lead_k;
  logic [7:0] mosi_seq, rx_got;
  logic       sclk_first;

  function automatic logic [7:0] bit_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Expected MOSI capture (bit k = k-th bit on the wire) for a given tx byte.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
`ifdef SPI_MSB_FIRST_EN
    return bit_rev(b);
`else
    return b;
`endif
  endfunction

  // driver: one transfer, accepting edge = cycle 0; start pulses at p1/p2 (0 = none)
  task automatic run_xfer(input logic p, input logic h, input logic [1:0] sel,
                          input logic [7:0] tx, input int p1, input int p2);
    logic prev;
    cpol = p; cpha = h; cs_sel = sel; tx_data = tx; start = 1'b1;
    lat = -1; cs_low_cnt = 0; load_cnt = 0; load_bad = 0; busy_drop = 0;
    bad_cs = 0; lead_k = 0; mosi_seq = '0; rx_got = 'x;
    @(posedge clk);
    #1;
    start = 1'b0;
    cpol = ~p; cpha = ~h; cs_sel = sel + 2'd1; tx_data = ~tx;
    prev = sclk;
    sclk_first = sclk;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (cs[sel] === 1'b0) cs_low_cnt++;
      if (cs != '1 && cs !== ~(4'b0001 << sel)) bad_cs++;
      if (load) begin
        load_cnt++;
        if (cs[sel] !== 1'b0) load_bad++;
      end
      if (sclk !== prev && sclk !== p) begin
        if (lead_k < 8) mosi_seq[lead_k] = MOSI;
        lead_k++;
      end
      prev = sclk;
      if (done === 1'b1) begin
        lat = cyc;
        rx_got = rx_data;
        break;
      end
      if (busy !== 1'b1) busy_drop++;
      start = (cyc + 1 == p1) || (cyc + 1 == p2);
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; cs_sel = '0;
    tx_data = '0; loopback = 1'b1; slave_byte = '0;
    #23;
    n_tests++; if (cs !== 4'b1111) begin n_fail++; $display("FAIL reset_cs got=%b exp=1111", cs); end
    n_tests++; if ({sclk, MOSI, busy, done, load, check1} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl got=%b exp=000000", {sclk, MOSI, busy, done, load, check1}); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(3);
  endtask

  task automatic test_mode0;
    loopback = 1'b0; slave_byte = 8'h3C;
    run_xfer(1'b0, 1'b0, 2'd2, 8'hA5, 0, 0);
    n_tests++; if (lat !== 76) begin n_fail++; $display("FAIL m0_latency got=%0d exp=76", lat); end
    n_tests++; if (rx_got !== 8'h3C) begin n_fail++; $display("FAIL m0_rx got=%h exp=3c", rx_got); end
    n_tests++; if (mosi_seq !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi got=%b exp=10100101", mosi_seq); end
    n_tests++; if (cs_low_cnt !== 72) begin n_fail++; $display("FAIL m0_cs_low got=%0d exp=72", cs_low_cnt); end
    n_tests++; if (bad_cs !== 0) begin n_fail++; $display("FAIL m0_other_cs got=%0d exp=0", bad_cs); end
    n_tests++; if (load_cnt !== 1 || load_bad !== 0) begin
      n_fail++; $display("FAIL m0_load got=%0d/%0d exp=1/0", load_cnt, load_bad); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL m0_busy_at_done got=%b exp=0", busy); end
    idle_cycles(3);
  endtask

  task automatic test_mode3;
    loopback = 1'b1;
    run_xfer(1'b1, 1'b1, 2'd1, 8'h81, 0, 0);
    n_tests++; if (sclk_first !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_setup got=%b exp=1", sclk_first); end
    n_tests++; if (rx_got !== 8'h81) begin n_fail++; $display("FAIL m3_rx got=%h exp=81", rx_got); end
    n_tests++; if (load_cnt !== 1 || load_bad !== 0) begin
      n_fail++; $display("FAIL m3_load got=%0d/%0d exp=1/0", load_cnt, load_bad); end
    n_tests++; if (lead_k !== 8) begin n_fail++; $display("FAIL m3_leading_edges got=%0d exp=8", lead_k); end
    idle_cycles(5);
    n_tests++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk); end
  endtask

  task automatic test_bit_order;
    loopback = 1'b1;
    run_xfer(1'b0, 1'b0, 2'd0, 8'h01, 0, 0);
    n_tests++; if (mosi_seq !== wire_order(8'h01)) begin
      n_fail++; $display("FAIL order_mosi got=%b exp=%b", mosi_seq, wire_order(8'h01)); end
    n_tests++; if (rx_got !== 8'h01) begin n_fail++; $display("FAIL order_rx got=%h exp=01", rx_got); end
    idle_cycles(2);
    run_xfer(1'b0, 1'b1, 2'd3, 8'h3A, 0, 0);
    n_tests++; if (mosi_seq !== wire_order(8'h3A)) begin
      n_fail++; $display("FAIL mode1_mosi got=%b exp=%b", mosi_seq, wire_order(8'h3A)); end
    n_tests++; if (rx_got !== 8'h3A) begin n_fail++; $display("FAIL mode1_rx got=%h exp=3a", rx_got); end
    idle_cycles(2);
    run_xfer(1'b1, 1'b0, 2'd0, 8'hC6, 0, 0);
    n_tests++; if (mosi_seq !== wire_order(8'hC6)) begin
      n_fail++; $display("FAIL mode2_mosi got=%b exp=%b", mosi_seq, wire_order(8'hC6)); end
    n_tests++; if (rx_got !== 8'hC6) begin n_fail++; $display("FAIL mode2_rx got=%h exp=c6", rx_got); end
    idle_cycles(2);
  endtask

  task automatic test_ignore_start;
    int extra;
    loopback = 1'b1;
    run_xfer(1'b0, 1'b0, 2'd1, 8'h5A, 10, 40);
    n_tests++; if (lat !== 76) begin n_fail++; $display("FAIL ign_latency got=%0d exp=76", lat); end
    n_tests++; if (busy_drop !== 0) begin n_fail++; $display("FAIL ign_busy_drop got=%0d exp=0", busy_drop); end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL ign_requeued got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] sels [3];
    int done_t [3];
    int low_per [4];
    int dn, two_low, wrong;
    sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd3;
    dn = 0; two_low = 0; wrong = 0;
    for (int i = 0; i < 4; i++) low_per[i] = 0;
    for (int i = 0; i < 3; i++) done_t[i] = -1;
    loopback = 1'b1; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h96;
    cs_sel = sels[0]; start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 260; cyc++) begin
      if (cyc > 0) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (cs[i] === 1'b0) low_per[i]++;
      if (cs != '1) begin
        if ($countones(~cs) > 1) two_low++;
        if (dn < 3 && cs !== ~(4'b0001 << sels[dn])) wrong++;
      end
      if (done === 1'b1 && dn < 3) begin
        done_t[dn] = cyc;
        dn++;
        if (dn < 3) cs_sel = sels[dn];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    n_tests++; if (dn !== 3) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=3", dn); end
    n_tests++; if (done_t[0] !== 76) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=76", done_t[0]); end
    n_tests++; if (done_t[1] - done_t[0] !== 77 || done_t[2] - done_t[1] !== 77) begin
      n_fail++; $display("FAIL b2b_spacing got=%0d,%0d exp=77,77", done_t[1] - done_t[0], done_t[2] - done_t[1]); end
    n_tests++; if (two_low !== 0 || wrong !== 0) begin
      n_fail++; $display("FAIL b2b_cs_exclusive got=%0d/%0d exp=0/0", two_low, wrong); end
    n_tests++; if (low_per[0] !== 72 || low_per[1] !== 72 || low_per[2] !== 0 || low_per[3] !== 72) begin
      n_fail++; $display("FAIL b2b_cs_low got=%0d,%0d,%0d,%0d exp=72,72,0,72",
                         low_per[0], low_per[1], low_per[2], low_per[3]); end
    idle_cycles(3);
  endtask

  task automatic test_reset_mid;
    int dcount;
    loopback = 1'b1; cpol = 1'b1; cpha = 1'b0; cs_sel = 2'd2; tx_data = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (33) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++; if (cs !== 4'b1111) begin n_fail++; $display("FAIL rmid_cs got=%b exp=1111", cs); end
    n_tests++; if ({sclk, busy, done, check1, MOSI} !== 5'b0) begin
      n_fail++; $display("FAIL rmid_ctl got=%b exp=00000", {sclk, busy, done, check1, MOSI}); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rmid_rx got=%h exp=00", rx_data); end
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    n_tests++; if (dcount !== 0) begin n_fail++; $display("FAIL rmid_no_done got=%0d exp=0", dcount); end
  endtask

  initial begin
    test_reset;
    test_mode0;
    test_mode3;
    test_bit_order;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
